// File: rtl/alu_issue_unit_if.sv
// ----------------------------------------------------------------------------
// alu_issue_unit_if
// Groups the instruction handshake and the ALU operand/result bus used by
// alu_issue_unit.
//   instr_valid / instr / instr_ready : 32-bit instruction valid/ready handshake
//   alu_data1 / alu_data2 / alu_select: operands and function select to the ALU
//   alu_result                        : combinational result back from the ALU
// Modports:
//   master : instruction sender plus ALU side (drives instr*, alu_result)
//   slave  : the issue unit (drives instr_ready and the ALU operands/select)
// ----------------------------------------------------------------------------
interface alu_issue_unit_if #(
  parameter int DW = 8
);
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [DW-1:0] alu_data1;
  logic [DW-1:0] alu_data2;
  logic [2:0]    alu_select;
  logic [DW-1:0] alu_result;

  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_data1, alu_data2, alu_select
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_data1, alu_data2, alu_select
  );
endinterface

// File: rtl/alu_issue_unit.sv
// ----------------------------------------------------------------------------
// alu_issue_unit
// Issue/writeback sequencer in front of an 8-bit combinational ALU. Accepts
// one instruction at a time, reads operands from an internal register file,
// drives the ALU, waits the per-operation latency and writes the result back.
//
// Ports:
//   CLK          : clock, rising edge
//   RESET        : synchronous active-low reset
//   bus          : alu_issue_unit_if.slave (instruction handshake + ALU bus)
//   wb_valid     : one-cycle writeback pulse, with wb_addr / wb_data
//   illegal      : one-cycle pulse for an unsupported opcode
//   dbg_addr     : debug register read address
//   dbg_data     : combinational read of the addressed register
//
// Configuration macro:
//   ALU_ISSUE_SUB_EN : when defined, opcode 0x03 (sub) is supported; when
//                      undefined it decodes as illegal and no negation logic
//                      is built.
// ----------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  alu_issue_unit_if.slave   bus,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOADI, OP_MOV, OP_ADD, OP_AND, OP_OR: ok = 1'b1;
`ifdef ALU_ISSUE_SUB_EN
      OP_SUB: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] op_select(input logic [7:0] op);
    logic [2:0] sel;
    sel = 3'b000;
    case (op)
      OP_LOADI, OP_MOV: sel = 3'b000;
      OP_ADD, OP_SUB:   sel = 3'b001;
      OP_AND:           sel = 3'b010;
      OP_OR:            sel = 3'b011;
      default:          sel = 3'b000;
    endcase
    return sel;
  endfunction

`ifdef ALU_ISSUE_SUB_EN
  // Subtraction is done on the ALU adder by feeding it -src2.
  function automatic logic [DW-1:0] negate(input logic [DW-1:0] x);
    return ~x + {{(DW-1){1'b0}}, 1'b1};
  endfunction
`endif

  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    op_r;
  logic [2:0]    dest_r;
  logic [2:0]    src1_r;
  logic [DW-1:0] imm_r;           // imm_r[2:0] doubles as the src2 field
  logic [1:0]    cnt_r;
  logic [DW-1:0] regs_r [NREG];
  logic [DW-1:0] data1_r;
  logic [DW-1:0] data2_r;
  logic [2:0]    sel_r;
  logic          wb_valid_r;
  logic [2:0]    wb_addr_r;
  logic [DW-1:0] wb_data_r;
  logic          illegal_r;

  logic          accept_s;
  logic          issue_s;
  logic          wb_enter_s;
  logic          wb_commit_s;
  logic          legal_s;
  logic [2:0]    sel_s;
  logic [DW-1:0] data2_s;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    wb_enter_s  = 1'b0;
    wb_commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (legal_s) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 2'd1) begin
          wb_enter_s  = 1'b1;
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WB: begin
        wb_commit_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Decode of the latched instruction and operand-2 selection.
  always_comb begin
    legal_s = op_legal(op_r);
    sel_s   = op_select(op_r);
    data2_s = regs_r[imm_r[2:0]];
    case (op_r)
      OP_LOADI: data2_s = imm_r;
`ifdef ALU_ISSUE_SUB_EN
      OP_SUB:   data2_s = negate(regs_r[imm_r[2:0]]);
`endif
      default:  data2_s = regs_r[imm_r[2:0]];
    endcase
  end

  // Datapath: instruction latch, ALU drive, latency counter, writeback, regfile.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op_r       <= 8'h00;
      dest_r     <= 3'd0;
      src1_r     <= 3'd0;
      imm_r      <= {DW{1'b0}};
      cnt_r      <= 2'd0;
      data1_r    <= {DW{1'b0}};
      data2_r    <= {DW{1'b0}};
      sel_r      <= 3'b000;
      wb_valid_r <= 1'b0;
      wb_addr_r  <= 3'd0;
      wb_data_r  <= {DW{1'b0}};
      illegal_r  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (accept_s) begin
        op_r   <= bus.instr[31:24];
        dest_r <= bus.instr[18:16];
        src1_r <= bus.instr[10:8];
        imm_r  <= bus.instr[DW-1:0];
      end
      // Decoding at acceptance makes the pulse coincide with the ISSUE cycle.
      illegal_r <= accept_s & ~op_legal(bus.instr[31:24]);
      if (issue_s) begin
        data1_r <= regs_r[src1_r];
        data2_r <= data2_s;
        sel_r   <= sel_s;
        cnt_r   <= (sel_s == 3'b001) ? 2'd2 : 2'd1;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 2'd1;
      end
      wb_valid_r <= wb_enter_s;
      if (wb_enter_s) begin
        wb_addr_r <= dest_r;
        wb_data_r <= bus.alu_result;
      end
      // Commit at the end of WB so the value appears on dbg_data one cycle later.
      if (wb_commit_s) begin
        regs_r[wb_addr_r] <= wb_data_r;
      end
    end
  end

  assign bus.instr_ready = (state_r == ST_IDLE);
  assign bus.alu_data1   = data1_r;
  assign bus.alu_data2   = data2_r;
  assign bus.alu_select  = sel_r;
  assign wb_valid        = wb_valid_r;
  assign wb_addr         = wb_addr_r;
  assign wb_data         = wb_data_r;
  assign illegal         = illegal_r;
  assign dbg_data        = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_unit
// Self-checking bench for alu_issue_unit. A reference ALU closes the loop,
// a register model predicts each writeback and pushes it to a scoreboard that
// a negedge monitor pops on every wb_valid pulse. Timing, ALU drive and
// register contents are checked inline in each scenario task.
// ----------------------------------------------------------------------------
module tb_alu_issue_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       illegal;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_issue_unit_if #(.DW(8)) bus ();

  alu_issue_unit #(.NREG(8), .DW(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 CLK = ~CLK;

  // Reference combinational ALU.
  logic [7:0] alu_res;
  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_select)
      3'b000:  alu_res = bus.alu_data2;
      3'b001:  alu_res = bus.alu_data1 + bus.alu_data2;
      3'b010:  alu_res = bus.alu_data1 & bus.alu_data2;
      3'b011:  alu_res = bus.alu_data1 | bus.alu_data2;
      default: alu_res = 8'h00;
    endcase
  end
  assign bus.alu_result = alu_res;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wb_t;

  typedef struct {
    int         wb_k;
    int         ill_k;
    int         ill_n;
    int         busy;
    logic [2:0] sel2;
    logic [7:0] d1_2;
    logic [7:0] d2_2;
  } meas_t;

  wb_t        sb_q[$];
  wb_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  int         wb_seen = 0;
  int         wb_pushed = 0;
  logic [7:0] model_regs [8];
  logic       exp_legal;
  logic       exp_chk_d1;
  int         exp_lat;
  logic [2:0] exp_sel;
  logic [7:0] exp_d1;
  logic [7:0] exp_d2;
  logic [2:0] last_sel;
  logic [7:0] last_d1;
  logic [7:0] last_d2;
  logic       last_d1_ok;

  // Scoreboard monitor: every writeback pulse must match the oldest prediction.
  always @(negedge CLK) begin
    if (wb_valid) begin
      wb_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got addr=%0d data=%02h, required no writeback", wb_addr, wb_data);
      end else begin
        mon_e = sb_q.pop_front();
        if ({wb_addr, wb_data} !== mon_e) begin
          errors++;
          $display("FAIL wb_data got addr=%0d data=%02h, required addr=%0d data=%02h",
                   wb_addr, wb_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] low);
    return {op, 5'd0, d, 5'd0, s1, low};
  endfunction

  // Model the instruction and push the expected writeback.
  task automatic predict(input logic [31:0] ins);
    logic [7:0] op, a, b, imm, r;
    logic [2:0] d;
    op = ins[31:24]; d = ins[18:16]; imm = ins[7:0];
    a = model_regs[ins[10:8]]; b = model_regs[ins[2:0]];
    exp_legal = 1'b1; exp_lat = 1; exp_chk_d1 = 1'b0;
    exp_d1 = a; exp_d2 = b; exp_sel = 3'b000; r = 8'h00;
    case (op)
      8'h00: begin r = imm; exp_d2 = imm; end
      8'h01: r = b;
      8'h02: begin r = a + b; exp_sel = 3'b001; exp_lat = 2; exp_chk_d1 = 1'b1; end
      8'h03: begin
`ifdef ALU_ISSUE_SUB_EN
        r = a - b; exp_d2 = 8'h00 - b; exp_sel = 3'b001; exp_lat = 2; exp_chk_d1 = 1'b1;
`else
        exp_legal = 1'b0;
`endif
      end
      8'h04: begin r = a & b; exp_sel = 3'b010; exp_chk_d1 = 1'b1; end
      8'h05: begin r = a | b; exp_sel = 3'b011; exp_chk_d1 = 1'b1; end
      default: exp_legal = 1'b0;
    endcase
    if (exp_legal) begin
      sb_q.push_back({d, r});
      wb_pushed++;
      model_regs[d] = r;
      last_sel = exp_sel; last_d1 = exp_d1; last_d2 = exp_d2; last_d1_ok = exp_chk_d1;
    end
  endtask

  // Present an instruction and hold it until accepted (bounded).
  task automatic send(input logic [31:0] ins, output int waited);
    waited = 0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout ready=%b required=1 after %0d cycles", bus.instr_ready, waited);
      bus.instr_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      bus.instr_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] ins, output int waited);
    predict(ins);
    send(ins, waited);
  endtask

  // Sample cycles 1.. after the handshake until instr_ready returns.
  task automatic measure(output meas_t m);
    logic done;
    done = 1'b0;
    m.wb_k = 0; m.ill_k = 0; m.ill_n = 0; m.busy = 0;
    m.sel2 = 3'b000; m.d1_2 = 8'h00; m.d2_2 = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (!done) begin
        @(negedge CLK);
        if (wb_valid && m.wb_k == 0) m.wb_k = k;
        if (illegal) begin
          m.ill_n++;
          if (m.ill_k == 0) m.ill_k = k;
        end
        if (k == 2) begin
          m.sel2 = bus.alu_select; m.d1_2 = bus.alu_data1; m.d2_2 = bus.alu_data2;
        end
        if (bus.instr_ready) done = 1'b1;
        else m.busy++;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.instr_ready !== 1'b1 || wb_valid !== 1'b0 || illegal !== 1'b0 ||
        bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00 || bus.alu_select !== 3'b000 ||
        wb_addr !== 3'd0 || wb_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b wbv=%b ill=%b d1=%02h d2=%02h sel=%b wa=%0d wd=%02h, required 1 0 0 00 00 000 0 00",
               bus.instr_ready, wb_valid, illegal, bus.alu_data1, bus.alu_data2, bus.alu_select, wb_addr, wb_data);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg r%0d got %02h required 00", a, dbg_data);
      end
      model_regs[a] = 8'h00;
    end
    last_sel = 3'b000; last_d1 = 8'h00; last_d2 = 8'h00; last_d1_ok = 1'b1;
  endtask

  task automatic test_loadi();
    meas_t m;
    int w;
    logic [31:0] ins [2];
    ins[0] = mk(8'h00, 3'd1, 3'd0, 8'h05);
    ins[1] = mk(8'h00, 3'd2, 3'd0, 8'h03);
    for (int i = 0; i < 2; i++) begin
      issue(ins[i], w);
      measure(m);
      checks++;
      if (m.wb_k !== 3 || m.busy !== 3 || m.ill_n !== 0 || m.sel2 !== 3'b000 || m.d2_2 !== exp_d2) begin
        errors++;
        $display("FAIL loadi_%0d got wb_cycle=%0d busy=%0d ill=%0d sel=%b d2=%02h, required 3 3 0 000 %02h",
                 i, m.wb_k, m.busy, m.ill_n, m.sel2, m.d2_2, exp_d2);
      end
    end
    dbg_addr = 3'd1;
    #1;
    checks++;
    if (dbg_data !== 8'h05) begin
      errors++;
      $display("FAIL loadi_dbg r1 got %02h required 05", dbg_data);
    end
  endtask

  task automatic test_add();
    meas_t m;
    int w;
    issue(mk(8'h02, 3'd3, 3'd1, 8'h02), w);
    measure(m);
    checks++;
    if (m.sel2 !== 3'b001 || m.d1_2 !== 8'h05 || m.d2_2 !== 8'h03 || m.wb_k !== 4 || m.busy !== 4) begin
      errors++;
      $display("FAIL add_issue got sel=%b d1=%02h d2=%02h wb_cycle=%0d busy=%0d, required 001 05 03 4 4",
               m.sel2, m.d1_2, m.d2_2, m.wb_k, m.busy);
    end
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 8'h08) begin
      errors++;
      $display("FAIL add_dbg r3 got %02h required 08", dbg_data);
    end
  endtask

  task automatic test_sub();
    meas_t m;
    int w;
    issue(mk(8'h03, 3'd4, 3'd2, 8'h01), w);
    measure(m);
    checks++;
`ifdef ALU_ISSUE_SUB_EN
    if (m.sel2 !== 3'b001 || m.d1_2 !== 8'h03 || m.d2_2 !== 8'hFB || m.wb_k !== 4 || m.ill_n !== 0) begin
      errors++;
      $display("FAIL sub_issue got sel=%b d1=%02h d2=%02h wb_cycle=%0d ill=%0d, required 001 03 fb 4 0",
               m.sel2, m.d1_2, m.d2_2, m.wb_k, m.ill_n);
    end
`else
    if (m.ill_k !== 1 || m.ill_n !== 1 || m.wb_k !== 0 || m.busy !== 1) begin
      errors++;
      $display("FAIL sub_illegal got ill_cycle=%0d ill_n=%0d wb_cycle=%0d busy=%0d, required 1 1 0 1",
               m.ill_k, m.ill_n, m.wb_k, m.busy);
    end
`endif
    dbg_addr = 3'd4;
    #1;
    checks++;
    if (dbg_data !== model_regs[4]) begin
      errors++;
      $display("FAIL sub_dbg r4 got %02h required %02h", dbg_data, model_regs[4]);
    end
  endtask

  task automatic test_logic();
    meas_t m;
    int w;
    logic [31:0] ins [6];
    logic [7:0]  want [8];
    ins[0] = mk(8'h00, 3'd1, 3'd0, 8'hF0);
    ins[1] = mk(8'h00, 3'd2, 3'd0, 8'h3C);
    ins[2] = mk(8'h04, 3'd5, 3'd1, 8'h02);
    ins[3] = mk(8'h05, 3'd6, 3'd1, 8'h02);
    ins[4] = mk(8'h01, 3'd7, 3'd0, 8'h06);
    ins[5] = mk(8'h02, 3'd1, 3'd1, 8'h01);
    for (int i = 0; i < 6; i++) begin
      issue(ins[i], w);
      measure(m);
      checks++;
      if (m.wb_k !== 2 + exp_lat || m.busy !== 2 + exp_lat || m.ill_n !== 0 ||
          m.sel2 !== exp_sel || m.d2_2 !== exp_d2 || (exp_chk_d1 && m.d1_2 !== exp_d1)) begin
        errors++;
        $display("FAIL logic_op_%0d got wb_cycle=%0d busy=%0d sel=%b d1=%02h d2=%02h, required %0d %0d %b %02h %02h",
                 i, m.wb_k, m.busy, m.sel2, m.d1_2, m.d2_2, 2 + exp_lat, 2 + exp_lat, exp_sel, exp_d1, exp_d2);
      end
    end
    want[1] = 8'hE0; want[5] = 8'h30; want[6] = 8'hFC; want[7] = 8'hFC;
    for (int a = 5; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      checks++;
      if (dbg_data !== want[a]) begin
        errors++;
        $display("FAIL logic_dbg r%0d got %02h required %02h", a, dbg_data, want[a]);
      end
    end
    dbg_addr = 3'd1;
    #1;
    checks++;
    if (dbg_data !== want[1]) begin
      errors++;
      $display("FAIL logic_dbg_self r1 got %02h required %02h", dbg_data, want[1]);
    end
  endtask

  task automatic test_illegal();
    meas_t m;
    int w;
    issue(mk(8'h07, 3'd2, 3'd1, 8'h01), w);
    @(negedge CLK);
    checks++;
    if (illegal !== 1'b1 || bus.instr_ready !== 1'b0 || wb_valid !== 1'b0 ||
        bus.alu_select !== last_sel || bus.alu_data2 !== last_d2 ||
        (last_d1_ok && bus.alu_data1 !== last_d1)) begin
      errors++;
      $display("FAIL illegal_cycle1 got ill=%b ready=%b wbv=%b sel=%b d1=%02h d2=%02h, required 1 0 0 %b %02h %02h",
               illegal, bus.instr_ready, wb_valid, bus.alu_select, bus.alu_data1, bus.alu_data2,
               last_sel, last_d1, last_d2);
    end
    // Next instruction presented during the busy cycle and held.
    bus.instr = mk(8'h00, 3'd0, 3'd0, 8'h5A);
    bus.instr_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (illegal !== 1'b0 || bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_cycle2 got ill=%b ready=%b, required 0 1", illegal, bus.instr_ready);
    end
    issue(mk(8'h00, 3'd0, 3'd0, 8'h5A), w);
    measure(m);
    checks++;
    if (w !== 0 || m.wb_k !== 3 || m.ill_n !== 0) begin
      errors++;
      $display("FAIL illegal_next got wait=%0d wb_cycle=%0d ill=%0d, required 0 3 0", w, m.wb_k, m.ill_n);
    end
  endtask

  task automatic test_back_to_back();
    meas_t m;
    int w;
    issue(mk(8'h05, 3'd3, 3'd5, 8'h00), w);
    issue(mk(8'h04, 3'd4, 3'd3, 8'h07), w);
    checks++;
    if (w !== 4) begin
      errors++;
      $display("FAIL b2b_interval_short got %0d cycles, required 4", w);
    end
    measure(m);
    issue(mk(8'h02, 3'd2, 3'd4, 8'h04), w);
    issue(mk(8'h02, 3'd2, 3'd2, 8'h05), w);
    checks++;
    if (w !== 5) begin
      errors++;
      $display("FAIL b2b_interval_long got %0d cycles, required 5", w);
    end
    measure(m);
    checks++;
    if (m.wb_k !== 4 || m.busy !== 4) begin
      errors++;
      $display("FAIL b2b_last got wb_cycle=%0d busy=%0d, required 4 4", m.wb_k, m.busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    send(mk(8'h02, 3'd6, 3'd1, 8'h02), w);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.instr_ready !== 1'b1 || wb_valid !== 1'b0 || bus.alu_select !== 3'b000 ||
        bus.alu_data1 !== 8'h00 || bus.alu_data2 !== 8'h00) begin
      errors++;
      $display("FAIL midwait_reset got ready=%b wbv=%b sel=%b d1=%02h d2=%02h, required 1 0 000 00 00",
               bus.instr_ready, wb_valid, bus.alu_select, bus.alu_data1, bus.alu_data2);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        errors++;
        $display("FAIL midwait_reg r%0d got %02h required 00", a, dbg_data);
      end
      model_regs[a] = 8'h00;
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_drain();
    repeat (8) @(negedge CLK);
    checks++;
    if (sb_q.size() !== 0 || wb_seen !== wb_pushed) begin
      errors++;
      $display("FAIL drain got pending=%0d seen=%0d, required 0 %0d", sb_q.size(), wb_seen, wb_pushed);
    end
  endtask

  initial begin
    RESET = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 32'h0000_0000;
    dbg_addr = 3'd0;
    test_reset();
    test_loadi();
    test_add();
    test_sub();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wait();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
